// File: rtl/number_glyph_writer.sv
// rtl/number_glyph_writer.sv - copies one ROM digit glyph into the 1-bit overlay framebuffer
// Reads glyph pixels in raster order and writes them at (x, y), clipping at the framebuffer edge.
module number_glyph_writer #(
  parameter int WIDTH     = 24,
  parameter int HEIGHT    = 24,
  parameter int NUM_IMGS  = 10,
  parameter int FB_WIDTH  = 320,
  parameter int FB_HEIGHT = 180,
  localparam int ROM_AW   = $clog2(WIDTH*HEIGHT*NUM_IMGS),
  localparam int FB_AW    = $clog2(FB_WIDTH*FB_HEIGHT)
) (
  input  logic              pixel_clk_in,
  input  logic              rst_in,
  input  logic              start_in,
  input  logic [10:0]       x_in,
  input  logic [9:0]        y_in,
  input  logic [3:0]        number_in,
  output logic              busy_out,
  output logic              done_out,
  output logic              error_out,
  output logic [ROM_AW-1:0] rom_addr_out,
  input  logic              rom_data_in,
  output logic [FB_AW-1:0]  fb_addr_out,
  output logic              fb_data_out,
  output logic              fb_we_out
);
  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(HEIGHT);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  logic [10:0]       x_q, x_d;
  logic [9:0]        y_q, y_d;
  logic [3:0]        num_q, num_d;
  logic [11:0]       px0_q, px0_d, px1_q, px1_d;
  logic [10:0]       py0_q, py0_d, py1_q, py1_d;
  logic              v0_q, v0_d, v1_q, v1_d;
  logic [FB_AW-1:0]  fb_addr_q, fb_addr_d;
  logic              fb_data_q, fb_data_d;
  logic              fb_we_q, fb_we_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    x_d     = x_q;
    y_d     = y_q;
    num_d   = num_q;
    err_d   = 1'b0;

    // Pixel coordinates travel alongside the two-cycle ROM latency.
    v0_d  = (state_q == ISSUE);
    px0_d = 12'(x_q) + 12'(col_q);
    py0_d = 11'(y_q) + 11'(row_q);
    v1_d  = v0_q;
    px1_d = px0_q;
    py1_d = py0_q;

    fb_we_d   = v1_q && (px1_q < 12'(FB_WIDTH)) && (py1_q < 11'(FB_HEIGHT));
    fb_data_d = fb_we_d ? rom_data_in : 1'b0;
    fb_addr_d = fb_we_d ? (FB_AW'(py1_q) * FB_AW'(FB_WIDTH) + FB_AW'(px1_q)) : '0;

    case (state_q)
      IDLE: begin
        if (start_in) begin
          if (32'(number_in) < NUM_IMGS) begin
            x_d     = x_in;
            y_d     = y_in;
            num_d   = number_in;
            col_d   = '0;
            row_d   = '0;
            state_d = ISSUE;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (col_q == CW'(WIDTH-1)) begin
          col_d = '0;
          if (row_q == RW'(HEIGHT-1)) begin
            row_d   = '0;
            state_d = DRAIN;
          end else begin
            row_d = row_q + 1'b1;
          end
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      DRAIN: begin
        if (!v0_q && !v1_q) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == ISSUE) || (state_d == DRAIN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q   <= IDLE;
      col_q     <= '0;
      row_q     <= '0;
      x_q       <= '0;
      y_q       <= '0;
      num_q     <= '0;
      px0_q     <= '0;
      py0_q     <= '0;
      px1_q     <= '0;
      py1_q     <= '0;
      v0_q      <= 1'b0;
      v1_q      <= 1'b0;
      fb_addr_q <= '0;
      fb_data_q <= 1'b0;
      fb_we_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      row_q     <= row_d;
      x_q       <= x_d;
      y_q       <= y_d;
      num_q     <= num_d;
      px0_q     <= px0_d;
      py0_q     <= py0_d;
      px1_q     <= px1_d;
      py1_q     <= py1_d;
      v0_q      <= v0_d;
      v1_q      <= v1_d;
      fb_addr_q <= fb_addr_d;
      fb_data_q <= fb_data_d;
      fb_we_q   <= fb_we_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    rom_addr_out = '0;
    if (state_q == ISSUE)
      rom_addr_out = ROM_AW'(num_q) * ROM_AW'(WIDTH*HEIGHT) + ROM_AW'(row_q) * ROM_AW'(WIDTH) + ROM_AW'(col_q);
  end

  assign busy_out    = busy_q;
  assign done_out    = done_q;
  assign error_out   = err_q;
  assign fb_addr_out = fb_addr_q;
  assign fb_data_out = fb_data_q;
  assign fb_we_out   = fb_we_q;
endmodule

// File: tb/tb_number_glyph_writer.sv
// tb/tb_number_glyph_writer.sv - directed scoreboard bench for number_glyph_writer
module tb_number_glyph_writer;
  localparam int W = 24, H = 24, FBW = 320, FBH = 180;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [10:0] x = '0;
  logic [9:0]  y = '0;
  logic [3:0]  number = '0;
  logic        busy_out, done_out, error_out;
  logic [12:0] rom_addr_out;
  logic        rom_data_in = 1'b0;
  logic [15:0] fb_addr_out;
  logic        fb_data_out, fb_we_out;

  number_glyph_writer dut (
    .pixel_clk_in(clk), .rst_in(rst), .start_in(start), .x_in(x), .y_in(y),
    .number_in(number), .busy_out(busy_out), .done_out(done_out), .error_out(error_out),
    .rom_addr_out(rom_addr_out), .rom_data_in(rom_data_in),
    .fb_addr_out(fb_addr_out), .fb_data_out(fb_data_out), .fb_we_out(fb_we_out)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int wcount = 0;
  int first_cyc = -1;
  int first_addr = -1;
  logic rom_mem [0:5759];
  logic rom_r1 = 1'b0;
  logic [16:0] exp_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  // Two-cycle glyph ROM
  always @(posedge clk) begin
    rom_r1      <= rom_mem[rom_addr_out];
    rom_data_in <= rom_r1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (fb_we_out === 1'b1) begin
      if (wcount == 0) begin
        first_cyc  = cyc;
        first_addr = int'(fb_addr_out);
      end
      wcount++;
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 1, 0);
      end else begin
        logic [16:0] e;
        e = exp_q.pop_front();
        chk("fb_addr", 32'(fb_addr_out), 32'(e[16:1]));
        chk("fb_data", 32'(fb_data_out), 32'(e[0]));
      end
    end
  end

  task automatic push_glyph(input int n, input int gx, input int gy);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        if (gx + c < FBW && gy + r < FBH)
          exp_q.push_back({16'((gy + r) * FBW + gx + c), rom_mem[n*W*H + r*W + c]});
  endtask

  task automatic begin_copy(input int n, input int gx, input int gy, output int s);
    wcount = 0;
    first_cyc = -1;
    first_addr = -1;
    number = 4'(n);
    x = 11'(gx);
    y = 10'(gy);
    start = 1'b1;
    s = cyc;
  endtask

  task automatic run_until_done(input int s, input bit hold);
    int dcyc;
    dcyc = -1;
    for (int i = 0; i < 700; i++) begin
      @(posedge clk); #1;
      if (!hold) start = 1'b0;
      if (cyc == s + 1) chk("busy_first", 32'(busy_out), 1);
      if (cyc == s + 3 + W*H) chk("busy_last", 32'(busy_out), 1);
      if (done_out === 1'b1) begin
        dcyc = cyc;
        chk("busy_at_done", 32'(busy_out), 0);
        break;
      end
    end
    chk("done_cycle", dcyc, s + 4 + W*H);
  endtask

  initial begin
    int s, s2;
    for (int i = 0; i < 5760; i++) rom_mem[i] = 1'($urandom);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy_out), 0);
    chk("rst_done", 32'(done_out), 0);
    chk("rst_we", 32'(fb_we_out), 0);
    chk("rst_rom_addr", 32'(rom_addr_out), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Glyph 3 at origin
    push_glyph(3, 0, 0);
    begin_copy(3, 0, 0, s);
    run_until_done(s, 0);
    chk("g3_writes", wcount, 576);
    chk("g3_first_cyc", first_cyc, s + 4);
    chk("g3_first_addr", first_addr, 0);
    chk("g3_queue_empty", exp_q.size(), 0);

    // Glyph 9 clipped at bottom-right
    @(posedge clk); #1;
    push_glyph(9, 310, 170);
    begin_copy(9, 310, 170, s);
    run_until_done(s, 0);
    chk("g9_writes", wcount, 100);
    chk("g9_first_addr", first_addr, 54710);
    chk("g9_queue_empty", exp_q.size(), 0);

    // Out-of-range glyph index
    @(posedge clk); #1;
    begin_copy(12, 5, 5, s);
    @(posedge clk); #1;
    start = 1'b0;
    chk("err_pulse", 32'(error_out), 1);
    chk("err_busy", 32'(busy_out), 0);
    chk("err_rom_addr", 32'(rom_addr_out), 0);
    @(posedge clk); #1;
    chk("err_cleared", 32'(error_out), 0);
    chk("err_busy2", 32'(busy_out), 0);
    chk("err_no_writes", wcount, 0);

    // Start held high through busy and DONE
    @(posedge clk); #1;
    push_glyph(1, 100, 50);
    push_glyph(1, 100, 50);
    begin_copy(1, 100, 50, s);
    run_until_done(s, 1);
    chk("hold_writes_first", wcount, 576);
    @(posedge clk); #1;
    chk("hold_idle_after_done", 32'(busy_out), 0);
    s2 = cyc;
    chk("hold_restart_cycle", s2, s + 5 + W*H);
    run_until_done(s2, 0);
    chk("hold_writes_total", wcount, 1152);
    chk("hold_queue_empty", exp_q.size(), 0);

    // Asynchronous reset mid-copy
    @(posedge clk); #1;
    push_glyph(2, 40, 30);
    begin_copy(2, 40, 30, s);
    @(posedge clk); #1;
    start = 1'b0;
    while (cyc < s + 200) begin
      @(posedge clk); #1;
    end
    #2;
    rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy_out), 0);
    chk("arst_we", 32'(fb_we_out), 0);
    chk("arst_addr", 32'(fb_addr_out), 0);
    chk("arst_data", 32'(fb_data_out), 0);
    chk("arst_rom_addr", 32'(rom_addr_out), 0);
    chk("arst_done", 32'(done_out), 0);
    @(posedge clk); #1;
    chk("arst_writes", wcount, 196);
    chk("arst_remaining", exp_q.size(), 576 - 196);
    exp_q.delete();
    rst = 1'b0;
    @(posedge clk); #1;
    chk("arst_no_done", 32'(done_out), 0);

    push_glyph(0, 7, 9);
    begin_copy(0, 7, 9, s);
    run_until_done(s, 0);
    chk("post_rst_writes", wcount, 576);
    chk("post_rst_queue", exp_q.size(), 0);

    // Single visible pixel at the last framebuffer location
    @(posedge clk); #1;
    push_glyph(0, 319, 179);
    begin_copy(0, 319, 179, s);
    run_until_done(s, 0);
    chk("corner_writes", wcount, 1);
    chk("corner_addr", first_addr, 57599);
    chk("corner_queue", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/number_glyph_writer.md
# number_glyph_writer

Writes one 24x24 1-bit digit glyph from the number glyph ROM into a 1-bit overlay framebuffer RAM at a requested (x, y) position. It is the write-side counterpart of the transparent digit sprite path: instead of overlaying a glyph on the live scan, it copies the glyph once into framebuffer memory, which the display scan-out then reads. The block sits between score/HUD control logic (start handshake) and two memories: the glyph ROM (read port) and the framebuffer (write port).

## Interface
- WIDTH, 24, glyph width in pixels
- HEIGHT, 24, glyph height in pixels
- NUM_IMGS, 10, glyphs stored in ROM (glyph n at base n*WIDTH*HEIGHT)
- FB_WIDTH, 320, framebuffer width in pixels
- FB_HEIGHT, 180, framebuffer height in pixels
- pixel_clk_in  in  1  single clock; all logic on its rising edge
- rst_in  in  1  reset, asynchronous, active-high
- start_in  in  1  request a glyph copy; sampled only in IDLE
- x_in  in  11  left column of glyph in framebuffer; latched on accept
- y_in  in  10  top row of glyph in framebuffer; latched on accept
- number_in  in  4  glyph index; latched on accept
- busy_out  out  1  high from first ISSUE cycle through last write cycle
- done_out  out  1  one-cycle pulse after a copy completes
- error_out  out  1  one-cycle pulse when start carries number_in >= NUM_IMGS
- rom_addr_out  out  clog2(WIDTH*HEIGHT*NUM_IMGS)  glyph ROM read address
- rom_data_in  in  1  glyph ROM data, valid exactly 2 cycles after rom_addr_out
- fb_addr_out  out  clog2(FB_WIDTH*FB_HEIGHT)  framebuffer write address, row-major (y*FB_WIDTH + x)
- fb_data_out  out  1  pixel value to write (1 = digit ink, 0 = clear)
- fb_we_out  out  1  framebuffer write enable

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE: start_in=1 with number_in < NUM_IMGS -> latch x, y, number; zero col/row counters; go ISSUE. start_in=1 with number_in >= NUM_IMGS -> pulse error_out next cycle, stay IDLE, no memory traffic.
- ISSUE: one ROM read per cycle, rom_addr_out = number*WIDTH*HEIGHT + row*WIDTH + col (combinational from counters). col counts 0..WIDTH-1, wraps to 0 and increments row; after pixel (WIDTH-1, HEIGHT-1) go DRAIN.
- Pixel coordinates (x+col, y+row) delay-matched alongside the ROM pipeline in a 3-stage shift register with a valid bit.
- DRAIN: no new reads; wait until pipeline valid bits empty, then DONE.
- DONE: done_out=1 for one cycle, busy_out=0, return to IDLE. start_in during DONE is ignored.
- Writes carry both 0 and 1 pixels, so a new glyph fully overwrites the old one at the same position.
- Clipping: pixel with x+col >= FB_WIDTH or y+row >= FB_HEIGHT produces no write (fb_we_out=0) but still occupies its cycle. Sums computed at 12/11 bits, no wrap-around.
- start_in while busy (ISSUE/DRAIN) is ignored; no queueing.
- rom_addr_out holds 0 outside ISSUE.

## Timing
- Reset (asynchronous, any state): state IDLE, counters and pipeline valids 0; busy_out, done_out, error_out, fb_we_out, fb_data_out, fb_addr_out, rom_addr_out all 0.
- fb_addr_out, fb_data_out, fb_we_out are registered.
- Start accepted in cycle S. Pixel k (k = row*WIDTH+col) ROM address in cycle S+1+k; rom_data_in valid S+3+k; framebuffer write visible S+4+k.
- busy_out high cycles S+1 .. S+3+WIDTH*HEIGHT; last write in S+3+WIDTH*HEIGHT.
- done_out high in cycle S+4+WIDTH*HEIGHT (580 for defaults); next start accepted at S+5+WIDTH*HEIGHT at earliest.
- error_out high in cycle S+1 for a rejected start.
- Reset asserted mid-copy: remaining writes abandoned immediately, no done_out; partial glyph stays in framebuffer.

## Test plan
- Start number=3, x=0, y=0 with a 2-cycle ROM model -> exactly 576 writes, first fb_addr 0 at S+4, address for pixel (col 5, row 2) = 645, fb_data matches ROM words 1728..2303 in order, done_out at S+580.
- Start number=9, x=310, y=170 -> writes only for col 0..9, row 0..9 (100 writes); first write fb_addr 170*320+310 = 54710; done_out still at S+580.
- Start number=12 -> error_out pulse at S+1, busy_out stays 0, no ROM/framebuffer activity, next valid start accepted.
- Start number=1, then start_in held high through busy and the DONE cycle -> one copy only during busy; second copy begins one cycle after DONE (accepted in IDLE).
- Assert rst_in asynchronously at S+200 -> all outputs 0 before next clock edge, no done_out; after release a new start number=0 completes normally.
- Start number=0 at x=319, y=179 -> exactly one write, fb_addr 57599, fb_data = ROM word 0.
